// File: rtl/cgra_ctx_sequencer.sv
// cgra_ctx_sequencer
//   Configuration-context store and sequencer for the CGRA array. Holds
//   CTX_DEPTH contexts of NUM_TILES configuration words each. The words are
//   loaded one at a time over a ready/valid port. A run replays contexts
//   0..ctx_last, one per cycle, for loop_count iterations. A loop_count of 0
//   keeps the run going until abort.
//
// Ports
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   load_valid/ready  configuration write handshake (ready only in IDLE)
//   load_tile/ctx     write target; load_data is the configuration word
//   load_err          one-cycle pulse after a write to a non-existent tile
//   start             begin a run (IDLE only); latches ctx_last, loop_count
//   abort             end a run immediately (RUN only)
//   busy              high while running
//   cfg_valid         cfg_out carries a live context
//   cfg_out           flattened context, tile t at [t*CFG_W +: CFG_W]
//   ctx_idx/iter_idx  context index / zero-based iteration of cfg_out
//   done              one-cycle pulse on normal completion
module cgra_ctx_sequencer #(
  parameter int NUM_TILES = 12,
  parameter int CFG_W     = 121,
  parameter int CTX_DEPTH = 8,
  parameter int CTX_W     = 3,
  parameter int TILE_W    = 4,
  parameter int ITER_W    = 16
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [TILE_W-1:0]          load_tile,
  input  logic [CTX_W-1:0]           load_ctx,
  input  logic [CFG_W-1:0]           load_data,
  output logic                       load_err,
  input  logic                       start,
  input  logic [CTX_W-1:0]           ctx_last,
  input  logic [ITER_W-1:0]          loop_count,
  input  logic                       abort,
  output logic                       busy,
  output logic                       cfg_valid,
  output logic [NUM_TILES*CFG_W-1:0] cfg_out,
  output logic [CTX_W-1:0]           ctx_idx,
  output logic [ITER_W-1:0]          iter_idx,
  output logic                       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CFG_W-1:0]    mem [CTX_DEPTH][NUM_TILES];
  logic [CTX_W-1:0]    ptr_q, ctx_last_q;
  logic [ITER_W-1:0]   iter_q, loop_cnt_q;
  logic                last_q;
  logic                load_acc, tile_ok, emit, last_word;

  assign load_ready = (state_q == S_IDLE);
  assign busy       = (state_q == S_RUN);
  assign load_acc   = load_valid && load_ready;
  assign tile_ok    = (32'(load_tile) < NUM_TILES);
  // last_q marks that the final word is already on cfg_out. The RUN state
  // spends one more edge before DONE, so the done pulse lands
  // (ctx_last+1)*loop_count + 1 cycles after start.
  assign emit       = (state_q == S_RUN) && !abort && !last_q;
  assign last_word  = (loop_cnt_q != '0) && (ptr_q == ctx_last_q) &&
                      (iter_q == loop_cnt_q - ITER_W'(1));

  // Context storage: no reset, so its contents survive a mid-run reset.
  always_ff @(posedge CLK) begin
    if (load_acc && tile_ok)
      mem[load_ctx][load_tile] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)       state_d = S_IDLE;
        else if (last_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      ctx_last_q <= '0;
      iter_q     <= '0;
      loop_cnt_q <= '0;
      last_q     <= 1'b0;
      load_err   <= 1'b0;
      cfg_valid  <= 1'b0;
      cfg_out    <= '0;
      ctx_idx    <= '0;
      iter_idx   <= '0;
      done       <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_err  <= load_acc && !tile_ok;
      cfg_valid <= emit;
      done      <= (state_q == S_RUN) && !abort && last_q;
      if (state_q == S_IDLE && start) begin
        ctx_last_q <= ctx_last;
        loop_cnt_q <= loop_count;
        ptr_q      <= '0;
        iter_q     <= '0;
        last_q     <= 1'b0;
      end
      if (emit) begin
        for (int unsigned t = 0; t < NUM_TILES; t++)
          cfg_out[t*CFG_W +: CFG_W] <= mem[ptr_q][t];
        ctx_idx  <= ptr_q;
        iter_idx <= iter_q;
        last_q   <= last_word;
        if (ptr_q != ctx_last_q) begin
          ptr_q <= ptr_q + CTX_W'(1);
        end else begin
          ptr_q  <= '0;
          iter_q <= iter_q + ITER_W'(1);
        end
      end
    end
  end

endmodule
